// File: rtl/sipo_piso_ctrl_if.sv
// Parallel-side handshake bundle of the serial link controller.
// master = controller, slave = parallel datapath.
interface sipo_piso_ctrl_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/sipo_piso_ctrl.sv
// Serial link controller: SIPO capture with double-buffered word,
// gapless MSB-first PISO transmit.
module sipo_piso_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_en,
  input  logic sin,
  output logic rx_overrun,
  output logic sout,
  output logic sout_en,
  sipo_piso_ctrl_if.master bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic { R_IDLE, R_SHIFT } rx_st_t;
  typedef enum logic { T_IDLE, T_SHIFT } tx_st_t;

  rx_st_t           rx_st;
  logic [CW-1:0]    rx_cnt;
  logic [WIDTH-2:0] rx_shreg;
  logic [WIDTH-1:0] rx_word;
  logic             rx_done;
  logic             rx_free;

  tx_st_t           tx_st;
  logic [CW-1:0]    tx_cnt;
  logic [WIDTH-1:0] tx_shreg;
  logic             tx_acc;

  assign rx_word = {rx_shreg, sin};
  assign rx_done = rx_en && (rx_st == R_SHIFT || WIDTH == 1)
                   && (rx_cnt == LAST);
  // holding register frees up if it is being read on this same edge
  assign rx_free = !bus.rx_valid || bus.rx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st      <= R_IDLE;
      rx_cnt     <= '0;
      rx_shreg   <= '0;
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (!rx_en) begin
        rx_st  <= R_IDLE;
        rx_cnt <= '0;
      end else begin
        rx_st    <= R_SHIFT;
        rx_shreg <= rx_word[WIDTH-2:0];
        rx_cnt   <= (rx_cnt == LAST) ? '0 : rx_cnt + 1'b1;
      end
      if (rx_done && rx_free) begin
        bus.rx_data  <= rx_word;
        bus.rx_valid <= 1'b1;
      end else if (rx_done) begin
        rx_overrun <= 1'b1;
      end else if (bus.rx_valid && bus.rx_ready) begin
        bus.rx_valid <= 1'b0;
      end
    end
  end

  assign bus.tx_ready = (tx_st == T_IDLE) ||
                        (tx_st == T_SHIFT && tx_cnt == LAST);
  assign tx_acc = bus.tx_valid && bus.tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st    <= T_IDLE;
      tx_cnt   <= '0;
      tx_shreg <= '0;
      sout     <= 1'b0;
      sout_en  <= 1'b0;
    end else if (tx_acc) begin
      sout     <= bus.tx_data[WIDTH-1];
      sout_en  <= 1'b1;
      tx_shreg <= bus.tx_data << 1;
      tx_cnt   <= '0;
      tx_st    <= T_SHIFT;
    end else if (tx_st == T_SHIFT) begin
      if (tx_cnt != LAST) begin
        sout     <= tx_shreg[WIDTH-1];
        tx_shreg <= tx_shreg << 1;
        tx_cnt   <= tx_cnt + 1'b1;
      end else begin
        sout    <= 1'b0;
        sout_en <= 1'b0;
        tx_st   <= T_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_sipo_piso_ctrl.sv
// Bench for sipo_piso_ctrl: directed scenarios plus random traffic
// against a bit-queue / frame-accumulator reference model.
module tb_sipo_piso_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_en = 1'b0;
  logic sin = 1'b0;
  logic rx_overrun, sout, sout_en;

  sipo_piso_ctrl_if #(.WIDTH(W)) bus();

  sipo_piso_ctrl #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_en(rx_en),
    .sin(sin),
    .rx_overrun(rx_overrun),
    .sout(sout),
    .sout_en(sout_en),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int         m_bits;
  int         m_acc;
  bit         m_hv;
  int         m_hd;
  bit         m_ovr;
  bit         txq[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_bits = 0;
    m_acc  = 0;
    m_hv   = 0;
    m_hd   = 0;
    m_ovr  = 0;
    txq.delete();
  endtask

  // called right after a rising edge, using the inputs of that edge
  task automatic model_update();
    bit done;
    bit acc;
    done  = 0;
    m_ovr = 0;
    if (rx_en) begin
      m_acc  = (m_acc * 2 + int'(sin)) % (1 << W);
      m_bits = m_bits + 1;
      if (m_bits == W) begin
        done   = 1;
        m_bits = 0;
      end
    end else begin
      m_bits = 0;
    end
    if (done && (!m_hv || bus.rx_ready)) begin
      m_hd = m_acc;
      m_hv = 1;
    end else if (done) begin
      m_ovr = 1;
    end else if (m_hv && bus.rx_ready) begin
      m_hv = 0;
    end
    acc = bus.tx_valid && (txq.size() <= 1);
    if (txq.size() > 0) void'(txq.pop_front());
    if (acc)
      for (int i = W - 1; i >= 0; i--)
        txq.push_back(bus.tx_data[i]);
  endtask

  task automatic compare();
    check("rx_data", 32'(bus.rx_data), 32'(m_hd));
    check("rx_valid", 32'(bus.rx_valid), 32'(m_hv));
    check("rx_overrun", 32'(rx_overrun), 32'(m_ovr));
    check("sout", 32'(sout), txq.size() > 0 ? 32'(txq[0]) : 32'd0);
    check("sout_en", 32'(sout_en), 32'(txq.size() > 0));
    check("tx_ready", 32'(bus.tx_ready), 32'(txq.size() <= 1));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_rx(input logic [W-1:0] w, input logic rdy_last);
    for (int i = W - 1; i >= 0; i--) begin
      rx_en = 1'b1;
      sin = w[i];
      bus.rx_ready = (i == 0) ? rdy_last : 1'b0;
      cycle();
    end
    rx_en = 1'b0;
    bus.rx_ready = 1'b0;
  endtask

  task automatic consume();
    bus.rx_ready = 1'b1;
    cycle();
    bus.rx_ready = 1'b0;
  endtask

  task automatic tx_run(input logic [15:0] words, input int n,
                        output logic [15:0] seq, output int ecnt);
    int nacc;
    nacc = 0;
    seq = '0;
    ecnt = 0;
    bus.tx_data = words[15:8];
    bus.tx_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (bus.tx_valid && bus.tx_ready) nacc++;
      cycle();
      if (nacc == 1 && n == 2) bus.tx_data = words[7:0];
      if (nacc == n) bus.tx_valid = 1'b0;
      if (sout_en) begin
        seq = {seq[14:0], sout};
        ecnt++;
      end else if (ecnt > 0) begin
        break;
      end
    end
  endtask

  logic [15:0] seq;
  int ecnt;

  initial begin
    bus.rx_ready = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data = '0;
    model_reset();
    @(negedge clk);
    #1;
    compare();
    @(negedge clk);
    rst_n = 1'b1;

    repeat (20) cycle();

    send_rx(8'hA5, 1'b0);
    check("rx_a5_data", 32'(bus.rx_data), 32'hA5);
    check("rx_a5_valid", 32'(bus.rx_valid), 32'd1);
    consume();
    check("rx_a5_drop", 32'(bus.rx_valid), 32'd0);

    for (int i = 0; i < 5; i++) begin
      rx_en = 1'b1;
      sin = 1'b1;
      cycle();
    end
    rx_en = 1'b0;
    cycle();
    check("rx_abort_none", 32'(bus.rx_valid), 32'd0);
    send_rx(8'h3C, 1'b0);
    check("rx_3c_data", 32'(bus.rx_data), 32'h3C);
    consume();

    send_rx(8'h11, 1'b0);
    send_rx(8'h22, 1'b0);
    check("ovr_pulse", 32'(rx_overrun), 32'd1);
    check("ovr_data", 32'(bus.rx_data), 32'h11);
    cycle();
    check("ovr_once", 32'(rx_overrun), 32'd0);
    consume();

    send_rx(8'h11, 1'b0);
    send_rx(8'h22, 1'b1);
    check("rdy_pulse", 32'(rx_overrun), 32'd0);
    check("rdy_data", 32'(bus.rx_data), 32'h22);
    consume();

    tx_run(16'hC35A, 2, seq, ecnt);
    check("tx_seq", 32'(seq), 32'hC35A);
    check("tx_en_len", 32'(ecnt), 32'd16);

    bus.tx_data = 8'hFF;
    bus.tx_valid = 1'b1;
    cycle();
    bus.tx_valid = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_sout", 32'(sout), 32'd0);
    check("rst_sout_en", 32'(sout_en), 32'd0);
    check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tx_run(16'h8100, 1, seq, ecnt);
    check("tx_81_seq", 32'(seq), 32'h81);
    check("tx_81_len", 32'(ecnt), 32'd8);

    for (int k = 0; k < 3000; k++) begin
      rx_en = ($urandom_range(0, 9) != 0);
      sin = 1'($urandom);
      bus.rx_ready = ($urandom_range(0, 2) == 0);
      bus.tx_valid = 1'($urandom);
      bus.tx_data = W'($urandom);
      if ($urandom_range(0, 399) == 0) reset_pulse();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule
